// File: rtl/uart_trig_tx_if.sv
// Byte-queue / serial-line bundle for uart_trig_tx.
// master: the byte producer (drives baud, data, strobe). slave: the transmitter.
interface uart_trig_tx_if;
  logic [15:0] baud_cnt;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        full;
  logic        TX;
  logic        tx_busy;
  logic        tx_done;

  modport master (
    output baud_cnt, tx_data, trmt,
    input  full, TX, tx_busy, tx_done
  );

  modport slave (
    input  baud_cnt, tx_data, trmt,
    output full, TX, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_trig_tx.sv
// uart_trig_tx: FIFO-fed byte UART transmitter, 8N1 at a run-time baud.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit before the
// stop bit (11-bit frame). Default build sends plain 8N1 (10-bit frame).
module uart_trig_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_trig_tx_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  typedef enum logic { S_IDLE, S_TX } state_t;

  state_t                state_q, state_d;
  logic [7:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q;
  logic [FRAME_BITS-1:0] sh_q, frame_w;
  logic [15:0]           baud_q, baud_lat_q;
  logic [3:0]            bit_cnt_q;
  logic                  busy_q, done_q;
  logic                  push, load, done_d, empty, bit_tick, last_tick;
  logic [7:0]            head;

  assign empty     = (count_q == '0);
  assign push      = bus.trmt & ~full_q;
  assign bit_tick  = (baud_q == baud_lat_q);
  assign last_tick = (state_q == S_TX) && bit_tick && (bit_cnt_q == LAST_BIT);
  assign head      = mem[rptr_q];
  assign count_d   = count_q + CW'(push) - CW'(load);

`ifdef UART_TX_PARITY_EN
  assign frame_w = {1'b1, ^head, head, 1'b0};
`else
  assign frame_w = {1'b1, head, 1'b0};
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: load a frame whenever a byte is waiting and the line is free
  // (idle, or the current stop bit is ending -> back-to-back, no gap)
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          load    = 1'b1;
          state_d = S_TX;
        end
      end
      S_TX: begin
        if (last_tick) begin
          done_d = 1'b1;
          if (!empty) load = 1'b1;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset, the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= bus.tx_data;
  end

  // FIFO pointers, occupancy and registered full flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (load) rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(FIFO_DEPTH));
    end
  end

  // Shift register, baud and bit counters; ones shift in so TX idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q       <= '1;
      baud_q     <= '0;
      baud_lat_q <= '0;
      bit_cnt_q  <= '0;
    end else if (load) begin
      sh_q       <= frame_w;
      baud_q     <= '0;
      baud_lat_q <= bus.baud_cnt;
      bit_cnt_q  <= '0;
    end else if (state_q == S_TX) begin
      if (bit_tick) begin
        sh_q      <= {1'b1, sh_q[FRAME_BITS-1:1]};
        baud_q    <= '0;
        bit_cnt_q <= last_tick ? 4'd0 : bit_cnt_q + 4'd1;
      end else begin
        baud_q <= baud_q + 16'd1;
      end
    end
  end

  // Status flags registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == S_TX);
      done_q <= done_d;
    end
  end

  assign bus.TX      = sh_q[0];
  assign bus.full    = full_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_trig_tx.sv
// Bench for uart_trig_tx: a cycle-count FIFO/line model predicts which byte
// starts when and at what baud; a serial monitor decodes the line and
// compares every bit period, tx_busy, tx_done and full against it.
module tb_uart_trig_tx;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_trig_tx_if bus();
  uart_trig_tx #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0]  d;
    logic [15:0] b;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mq[$];
  exp_t       me, mo;
  int         cyc, m_end;
  bit         m_busy, m_full, m_fin, m_acc;

  function automatic logic [10:0] frame_of(logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  // Reference: a byte leaves the queue when the line is free (idle or at the
  // exact cycle the previous frame ends); a frame lasts FRAME*(baud+1) clocks.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); sb.delete();
      m_busy = 0; m_full = 0; cyc = 0; m_end = 0;
    end else begin
      cyc++;
      m_fin = m_busy && (cyc == m_end);
      m_acc = bus.trmt && !m_full;
      if ((!m_busy || m_fin) && mq.size() > 0) begin
        me.d = mq.pop_front();
        me.b = bus.baud_cnt;
        sb.push_back(me);
        m_end  = cyc + FRAME * (int'(bus.baud_cnt) + 1);
        m_busy = 1;
      end else if (m_fin) begin
        m_busy = 0;
      end
      if (m_acc) mq.push_back(bus.tx_data);
      m_full = (mq.size() == DEPTH);
    end
  end

  // Monitor: decode the serial line against the scoreboard
  int         fr_left = 0, fr_per = 1, idx;
  logic [10:0] fr_bits;
  bit         done_due = 0, fresh;

  always @(negedge clk) begin
    if (!rst_n) begin
      fr_left  = 0;
      done_due = 0;
    end else begin
      chk("full", bus.full, m_full);
      fresh = 0;
      if (fr_left == 0) begin
        if (done_due) begin
          chk("tx_done_pulse", bus.tx_done, 1);
          done_due = 0;
        end else begin
          chk("tx_done_quiet", bus.tx_done, 0);
        end
        chk("line_start", bus.TX, (sb.size() > 0) ? 0 : 1);
        if (bus.TX == 1'b0 && sb.size() > 0) begin
          mo      = sb.pop_front();
          fr_bits = frame_of(mo.d);
          fr_per  = int'(mo.b) + 1;
          fr_left = FRAME * fr_per;
          fresh   = 1;
        end else begin
          chk("tx_busy_idle", bus.tx_busy, 0);
        end
      end
      if (fr_left > 0) begin
        idx = (FRAME * fr_per - fr_left) / fr_per;
        chk("tx_bit", bus.TX, fr_bits[idx]);
        chk("tx_busy", bus.tx_busy, 1);
        if (!fresh) chk("tx_done_mid", bus.tx_done, 0);
        fr_left--;
        if (fr_left == 0) done_due = 1;
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_seq(input logic [7:0] d[$]);
    foreach (d[i]) begin
      bus.trmt    = 1'b1;
      bus.tx_data = d[i];
      step(1);
    end
    bus.trmt = 1'b0;
  endtask

  task automatic drain();
    int lim = 20000;
    while ((m_busy || mq.size() > 0 || fr_left > 0 || done_due) && lim > 0) begin
      step(1);
      lim--;
    end
    tests++;
    if (lim == 0) begin
      fails++;
      $display("FAIL drain_timeout: line still active after 20000 clocks");
    end
    step(2);
  endtask

  initial begin
    bus.trmt     = 1'b0;
    bus.tx_data  = 8'h00;
    bus.baud_cnt = 16'd3;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_TX", bus.TX, 1);
    chk("rst_busy", bus.tx_busy, 0);
    chk("rst_done", bus.tx_done, 0);
    chk("rst_full", bus.full, 0);
    rst_n = 1'b1;
    step(2);

    // 0xA5 at baud_cnt=3, with first-start latency check
    bus.trmt = 1'b1; bus.tx_data = 8'hA5;
    step(1);
    bus.trmt = 1'b0;
    chk("latency_k", bus.TX, 1);
    step(1);
    chk("latency_k1", bus.TX, 0);
    drain();

    // back-to-back frames at one clock per bit
    bus.baud_cnt = 16'd0;
    write_seq('{8'h00, 8'hFF, 8'h3C});
    drain();

    // fill the FIFO while busy; fifth write must be dropped
    bus.baud_cnt = 16'd5;
    write_seq('{8'h10});
    step(3);
    write_seq('{8'h11, 8'h12, 8'h13, 8'h14});
    chk("full_after_4", bus.full, 1);
    write_seq('{8'h15});
    chk("full_after_drop", bus.full, 1);
    drain();

    // baud change mid-frame applies to the next frame only
    bus.baud_cnt = 16'd3;
    write_seq('{8'hC3, 8'h96});
    step(10);
    bus.baud_cnt = 16'd7;
    drain();

    // randomized traffic and baud changes
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) bus.baud_cnt = 16'($urandom_range(0, 3));
      bus.trmt    = ($urandom_range(0, 3) == 0);
      bus.tx_data = 8'($urandom);
      step(1);
    end
    bus.trmt = 1'b0;
    drain();

    // asynchronous reset mid-frame with a full FIFO
    bus.baud_cnt = 16'd2;
    write_seq('{8'h5A, 8'hA5, 8'hFF, 8'h01, 8'h02});
    step(4);
    chk("pre_reset_full", bus.full, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_TX", bus.TX, 1);
    chk("async_rst_busy", bus.tx_busy, 0);
    chk("async_rst_full", bus.full, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(60);
    chk("post_reset_TX", bus.TX, 1);
    chk("post_reset_busy", bus.tx_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
